decode_stage: RTL and testbench

//  Pipelined RV32I(+M) instruction decoder for the pipelined core. Sits between fetch
//  and issue. Accepts {instr, pc} over a valid/ready handshake and emits a registered

---
 rtl/decode_stage.sv | 175 +++++++++++++++++
 tb/tb_decode_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode of the incoming word into a
// registered bundle, with a main register plus one skid entry for full rate under stall.
module decode_stage #(
    parameter bit ENABLE_M = 1'b1,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      out_cls,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_we,
    output logic [31:0]     out_imm,
    output logic            out_illegal
);
    localparam logic [3:0] C_ILL = 4'd0, C_ALUR = 4'd1, C_ALUI = 4'd2, C_LOAD = 4'd3,
                           C_STORE = 4'd4, C_BR = 4'd5, C_JAL = 4'd6, C_JALR = 4'd7,
                           C_LUI = 4'd8, C_AUIPC = 4'd9, C_MULDIV = 4'd10,
                           C_FENCE = 4'd11, C_SYS = 4'd12;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [3:0]      cls;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            illegal;
    } bundle_t;

    bundle_t dec, main_q, skid_q;
    logic    main_v, skid_v;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        legal;

    assign opc    = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
    assign imm_sh = {27'b0, in_instr[24:20]};

    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        dec.pc    = in_pc;
        case (opc)
            7'b0110011: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
                dec.funct3 = f3;
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec.cls = C_ALUR;
                    dec.alt = in_instr[30];
                end else if (f7 == 7'b0000001 && ENABLE_M) begin
                    dec.cls = C_MULDIV;
                end else begin
                    legal = 1'b0;
                end
            end
            7'b0010011: begin
                dec.cls = C_ALUI; dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15];
                dec.funct3 = f3;
                if (f3 == 3'b001) begin
                    dec.imm = imm_sh;
                    legal   = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec.imm = imm_sh;
                    dec.alt = in_instr[30];
                    legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end else begin
                    dec.imm = imm_i;
                end
            end
            7'b0000011: begin
                dec.cls = C_LOAD; dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15];
                dec.funct3 = f3; dec.imm = imm_i;
                legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            7'b0100011: begin
                dec.cls = C_STORE; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
                dec.funct3 = f3; dec.imm = imm_s;
                legal = (f3 < 3'b011);
            end
            7'b1100011: begin
                dec.cls = C_BR; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
                dec.funct3 = f3; dec.imm = imm_b;
                legal = !(f3 == 3'b010 || f3 == 3'b011);
            end
            7'b1101111: begin
                dec.cls = C_JAL; dec.rd = in_instr[11:7]; dec.imm = imm_j;
            end
            7'b1100111: begin
                dec.cls = C_JALR; dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15];
                dec.imm = imm_i;
                legal = (f3 == 3'b000);
            end
            7'b0110111: begin dec.cls = C_LUI;   dec.rd = in_instr[11:7]; dec.imm = imm_u; end
            7'b0010111: begin dec.cls = C_AUIPC; dec.rd = in_instr[11:7]; dec.imm = imm_u; end
            7'b0001111: begin dec.cls = C_FENCE; dec.funct3 = f3; end
            7'b1110011: begin
                dec.cls = C_SYS;
                legal   = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
            end
            default: legal = 1'b0;
        endcase
        // Illegal words keep only their pc so the exception path can report it
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    logic accept;
    assign in_ready = !skid_v;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || out_ready) begin
            // Skid is only occupied while in_ready is low, so it never races a new accept
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                main_v <= accept;
                if (accept) main_q <= dec;
            end
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign out_valid   = main_v;
    assign out_pc      = main_q.pc;
    assign out_cls     = main_q.cls;
    assign out_funct3  = main_q.funct3;
    assign out_alt     = main_q.alt;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd_we   = (main_q.rd != 5'd0);
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M enabled / disabled) share one stimulus stream
// and are checked every cycle against a queue-based model of the two-entry buffer.
module tb_decode_stage;
    logic clk = 1'b0, rstn, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        ir [2], ov [2], oalt [2], owe [2], oill [2];
    logic [31:0] opc [2], oimm [2];
    logic [3:0]  ocls [2];
    logic [2:0]  of3 [2];
    logic [4:0]  ord [2], ors1 [2], ors2 [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.ENABLE_M(1'b1), .PC_W(32)) dut_m (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov[0]), .out_ready(out_ready),
        .out_pc(opc[0]), .out_cls(ocls[0]), .out_funct3(of3[0]), .out_alt(oalt[0]),
        .out_rd(ord[0]), .out_rs1(ors1[0]), .out_rs2(ors2[0]), .out_rd_we(owe[0]),
        .out_imm(oimm[0]), .out_illegal(oill[0]));
    decode_stage #(.ENABLE_M(1'b0), .PC_W(32)) dut_i (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov[1]), .out_ready(out_ready),
        .out_pc(opc[1]), .out_cls(ocls[1]), .out_funct3(of3[1]), .out_alt(oalt[1]),
        .out_rd(ord[1]), .out_rs1(ors1[1]), .out_rs2(ors2[1]), .out_rd_we(owe[1]),
        .out_imm(oimm[1]), .out_illegal(oill[1]));

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd, rs1, rs2;
        logic        we;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t q0[$], q1[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Classify first, then fill fields from which operands/immediate each class uses.
    function automatic exp_t ref_dec(logic [31:0] i, logic [31:0] pc, bit en_m);
        exp_t e = '0;
        int c = 0;
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        case (i[6:0])
            7'h33: c = (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) ? 1 :
                       (f7 == 7'h01 && en_m) ? 10 : 0;
            7'h13: c = (f3 == 1) ? ((f7 == 0) ? 2 : 0) :
                       (f3 == 5) ? ((f7 == 0 || f7 == 7'h20) ? 2 : 0) : 2;
            7'h03: c = (f3 == 3 || f3 == 6 || f3 == 7) ? 0 : 3;
            7'h23: c = (f3 >= 3) ? 0 : 4;
            7'h63: c = (f3 == 2 || f3 == 3) ? 0 : 5;
            7'h6F: c = 6;
            7'h67: c = (f3 == 0) ? 7 : 0;
            7'h37: c = 8;
            7'h17: c = 9;
            7'h0F: c = 11;
            7'h73: c = (i == 32'h73 || i == 32'h0010_0073) ? 12 : 0;
            default: c = 0;
        endcase
        e.pc  = pc;
        e.cls = 4'(c);
        e.ill = (c == 0);
        if (c inside {1, 2, 3, 6, 7, 8, 9, 10}) e.rd  = i[11:7];
        if (c inside {1, 2, 3, 4, 5, 7, 10})    e.rs1 = i[19:15];
        if (c inside {1, 4, 5, 10})             e.rs2 = i[24:20];
        if (c inside {1, 2, 3, 4, 5, 7, 10, 11, 12}) e.f3 = f3;
        if (c == 1 || (c == 2 && f3 == 5)) e.alt = i[30];
        e.we = (e.rd != 0);
        case (c)
            2:       e.imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : 32'($signed(i[31:20]));
            3, 7:    e.imm = 32'($signed(i[31:20]));
            4:       e.imm = 32'($signed({i[31:25], i[11:7]}));
            5:       e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            6:       e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            8, 9:    e.imm = {i[31:12], 12'b0};
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    // Model: the stage holds at most two entries; accepting while two are held is refused.
    always @(posedge clk or negedge rstn) begin
        bit rdy, pop;
        if (!rstn) begin
            q0.delete(); q1.delete();
        end else if (flush) begin
            q0.delete(); q1.delete();
        end else begin
            rdy = (q0.size() < 2);
            pop = (q0.size() > 0) && out_ready;
            if (pop) begin void'(q0.pop_front()); void'(q1.pop_front()); end
            if (in_valid && rdy) begin
                q0.push_back(ref_dec(in_instr, in_pc, 1'b1));
                q1.push_back(ref_dec(in_instr, in_pc, 1'b0));
            end
        end
    end

    task automatic cmp(input int d, input int sz, input exp_t f);
        chk($sformatf("in_ready[%0d]", d), 128'(ir[d]), 128'(sz < 2));
        chk($sformatf("out_valid[%0d]", d), 128'(ov[d]), 128'(sz > 0));
        if (sz > 0)
            chk($sformatf("bundle[%0d]", d),
                128'({opc[d], ocls[d], of3[d], oalt[d], ord[d], ors1[d], ors2[d], owe[d],
                      oimm[d], oill[d]}), 128'(f));
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            cmp(0, q0.size(), (q0.size() > 0) ? q0[0] : exp_t'('0));
            cmp(1, q1.size(), (q1.size() > 0) ? q1[0] : exp_t'('0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = i; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i = $urandom;
        int r = $urandom_range(0, 99);
        if (r < 8) return i;
        if (r < 12) return ($urandom_range(0, 1) != 0) ? 32'h73 : 32'h0010_0073;
        case ($urandom_range(0, 10))
            0: i[6:0] = 7'h33;  1: i[6:0] = 7'h13;  2: i[6:0] = 7'h03;  3: i[6:0] = 7'h23;
            4: i[6:0] = 7'h63;  5: i[6:0] = 7'h6F;  6: i[6:0] = 7'h67;  7: i[6:0] = 7'h37;
            8: i[6:0] = 7'h17;  9: i[6:0] = 7'h0F;  default: i[6:0] = 7'h73;
        endcase
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            2: i[31:25] = 7'h01;
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        #12;
        chk("rst_valid", 128'(ov[0]), 128'(0));
        chk("rst_ready", 128'(ir[0]), 128'(1));
        chk("rst_data", 128'({opc[0], ocls[0], oimm[0], oill[0], owe[0]}), 128'(0));
        rstn = 1'b1;
        step();

        // addi x1,x0,-1
        send(32'hFFF0_0093, 32'h100);
        chk("addi_valid", 128'(ov[0]), 128'(1));
        chk("addi_fields", 128'({ocls[0], ord[0], ors1[0], owe[0], oimm[0]}),
            128'({4'd2, 5'd1, 5'd0, 1'b1, 32'hFFFF_FFFF}));
        send(32'hFE00_0EE3, 32'h104);
        chk("beq", 128'({ocls[0], ord[0], oimm[0]}), 128'({4'd5, 5'd0, 32'hFFFF_FFFC}));
        send(32'h1234_52B7, 32'h108);
        chk("lui", 128'({ocls[0], ord[0], oimm[0]}), 128'({4'd8, 5'd5, 32'h1234_5000}));
        send(32'h40B5_0533, 32'h10C);
        chk("sub", 128'({ocls[0], oalt[0]}), 128'({4'd1, 1'b1}));
        send(32'h02B5_0533, 32'h110);
        chk("mul_m", 128'({ocls[0], oill[0]}), 128'({4'd10, 1'b0}));
        chk("mul_nom", 128'({ocls[1], oill[1], opc[1]}), 128'({4'd0, 1'b1, 32'h110}));
        step();

        // stall: A,B fill both entries, C waits at the input
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h200);
        send(32'h0020_0093, 32'h204);
        in_valid = 1'b1; in_instr = 32'h0030_0093; in_pc = 32'h208;
        chk("stall_ready", 128'(ir[0]), 128'(0));
        step();
        chk("stall_hold", 128'({ov[0], opc[0], ir[0]}), 128'({1'b1, 32'h200, 1'b0}));
        out_ready = 1'b1;
        step();
        chk("rel_b", 128'({ov[0], opc[0], ir[0]}), 128'({1'b1, 32'h204, 1'b1}));
        step();
        in_valid = 1'b0;
        chk("rel_c", 128'({ov[0], opc[0]}), 128'({1'b1, 32'h208}));
        step();
        chk("rel_done", 128'(ov[0]), 128'(0));

        // flush with both entries full and an input offered
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h300);
        send(32'h0020_0093, 32'h304);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h308;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_empty", 128'({ov[0], ir[0]}), 128'({1'b0, 1'b1}));
        step();
        chk("flush_none", 128'(ov[0]), 128'(0));

        // asynchronous reset with both entries full
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h400);
        send(32'h0020_0093, 32'h404);
        #3 rstn = 1'b0;
        #1;
        chk("arst_state", 128'({ov[0], ir[0], ov[1], ir[1]}), 128'({1'b0, 1'b1, 1'b0, 1'b1}));
        chk("arst_data", 128'({opc[0], ocls[0], oimm[0], ord[0]}), 128'(0));
        #2 rstn = 1'b1;
        step();

        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 3);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            step();
        end
        in_valid = 1'b0; flush = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
